ex_fwd_hazard_ctrl: RTL and testbench

Forwarding and hazard controller for the 5-stage MIPS pipeline. It drives the EX-stage forwarding selects (ALUSrcA/ALUSrcB, 00 = register bus, 01 = Mem_ALUout, 10 = Wr_RegDi) and the load-use / jal-use stall and bubble controls. It keeps its own shadow copies of the EX source registers and the MEM/WB destination registers, so the decision is made from registered in-flight state. It also counts stall cycles for performance monitoring.

---
 rtl/ex_fwd_hazard_ctrl.sv | 128 ++++++++++++
 tb/tb_ex_fwd_hazard_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/ex_fwd_hazard_ctrl.sv
// EX-stage forwarding selects and load/jal-use stall control for the 5-stage MIPS pipeline.
// Forwarding is decided only from shadow copies of the in-flight EX/MEM/WB register fields.

module ex_fwd_sel (
  input  logic [4:0] src,
  input  logic       use_src,
  input  logic [4:0] mem_rw,
  input  logic       mem_regwrite,
  input  logic [1:0] mem_memtoreg,
  input  logic [4:0] wr_rw,
  input  logic       wr_regwrite,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    // Loads and jal results only exist at WB; the stall makes sure they are picked up there.
    if (use_src && mem_regwrite && mem_memtoreg == 2'b00 && mem_rw != 5'd0 && mem_rw == src)
      sel = 2'b01;
    else if (use_src && wr_regwrite && wr_rw != 5'd0 && wr_rw == src)
      sel = 2'b10;
  end
endmodule

module ex_fwd_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_valid,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regwrite,
  input  logic [1:0]       ex_memtoreg,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int NUM_OPS = 2;

  logic             hz;
  logic [4:0]       ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d;
  logic             ex_use_rs_q, ex_use_rs_d, ex_use_rt_q, ex_use_rt_d;
  logic [4:0]       mem_rw_q, mem_rw_d, wr_rw_q, wr_rw_d;
  logic             mem_regwrite_q, mem_regwrite_d, wr_regwrite_q, wr_regwrite_d;
  logic [1:0]       mem_memtoreg_q, mem_memtoreg_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Gated by reset so a stall drops the instant reset is asserted, not at the next edge.
  always_comb begin
    hz = ~reset & ex_regwrite & (ex_memtoreg != 2'b00) & (ex_rw != 5'd0) & id_valid &
         ((id_use_rs & (id_rs == ex_rw)) | (id_use_rt & (id_rt == ex_rw)));
  end

  always_comb begin
    ex_rs_d        = id_rs;
    ex_rt_d        = id_rt;
    ex_use_rs_d    = id_use_rs & id_valid & ~hz;
    ex_use_rt_d    = id_use_rt & id_valid & ~hz;
    mem_rw_d       = ex_rw;
    mem_regwrite_d = ex_regwrite;
    mem_memtoreg_d = ex_memtoreg;
    wr_rw_d        = mem_rw_q;
    wr_regwrite_d  = mem_regwrite_q;
    stall_cnt_d    = stall_cnt_q;
    if (hz && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_use_rs_q    <= 1'b0;
      ex_use_rt_q    <= 1'b0;
      mem_rw_q       <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memtoreg_q <= '0;
      wr_rw_q        <= '0;
      wr_regwrite_q  <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_use_rs_q    <= ex_use_rs_d;
      ex_use_rt_q    <= ex_use_rt_d;
      mem_rw_q       <= mem_rw_d;
      mem_regwrite_q <= mem_regwrite_d;
      mem_memtoreg_q <= mem_memtoreg_d;
      wr_rw_q        <= wr_rw_d;
      wr_regwrite_q  <= wr_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Operand 0 is rs (ALU A), operand 1 is rt (ALU B / store data).
  logic [NUM_OPS-1:0][4:0] ex_src;
  logic [NUM_OPS-1:0]      ex_use;
  logic [NUM_OPS-1:0][1:0] fwd;

  assign ex_src = {ex_rt_q, ex_rs_q};
  assign ex_use = {ex_use_rt_q, ex_use_rs_q};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    ex_fwd_sel u_sel (
      .src          (ex_src[i]),
      .use_src      (ex_use[i]),
      .mem_rw       (mem_rw_q),
      .mem_regwrite (mem_regwrite_q),
      .mem_memtoreg (mem_memtoreg_q),
      .wr_rw        (wr_rw_q),
      .wr_regwrite  (wr_regwrite_q),
      .sel          (fwd[i])
    );
  end

  assign ALUSrcA    = fwd[0];
  assign ALUSrcB    = fwd[1];
  assign pc_stall   = hz;
  assign ifid_stall = hz;
  assign idex_flush = hz;
  assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_ex_fwd_hazard_ctrl.sv
// Directed-vector bench: the driver pushes hand-computed expectations per cycle, the monitor
// pops and compares them mid-cycle. A second instance with CNT_W = 2 checks counter saturation.

module tb_ex_fwd_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rw;
  logic       id_use_rs, id_use_rt, id_valid, ex_regwrite;
  logic [1:0] ex_memtoreg;

  logic [1:0]  alu_a, alu_b, alu_a2, alu_b2;
  logic        pc_stall, ifid_stall, idex_flush, pc_stall2, ifid_stall2, idex_flush2;
  logic [15:0] stall_cnt;
  logic [1:0]  stall_cnt2;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  event chk_ev;

  always #5 clk = ~clk;

  ex_fwd_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_valid(id_valid), .ex_rw(ex_rw), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ALUSrcA(alu_a), .ALUSrcB(alu_b), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .idex_flush(idex_flush), .stall_cnt(stall_cnt)
  );

  ex_fwd_hazard_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_valid(id_valid), .ex_rw(ex_rw), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ALUSrcA(alu_a2), .ALUSrcB(alu_b2), .pc_stall(pc_stall2),
    .ifid_stall(ifid_stall2), .idex_flush(idex_flush2), .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s entry %0d: got %0d expected %0d", nm, n, act, exv);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] fa, input logic [1:0] fb, input logic st,
                              input int cnt);
    exp_t e;
    e.fa   = fa;
    e.fb   = fb;
    e.st   = st;
    e.cnt  = 16'(cnt);
    e.cnt2 = (cnt > 3) ? 2'd3 : 2'(cnt);
    return e;
  endfunction

  // Monitor: one expectation per sample point (mid-cycle, or on an explicit reset probe).
  initial begin : monitor
    int   n = 0;
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("ALUSrcA",     n, 32'(alu_a),      32'(e.fa));
        chk("ALUSrcB",     n, 32'(alu_b),      32'(e.fb));
        chk("pc_stall",    n, 32'(pc_stall),   32'(e.st));
        chk("ifid_stall",  n, 32'(ifid_stall), 32'(e.st));
        chk("idex_flush",  n, 32'(idex_flush), 32'(e.st));
        chk("stall_cnt",   n, 32'(stall_cnt),  32'(e.cnt));
        chk("stall_cnt_w2",n, 32'(stall_cnt2), 32'(e.cnt2));
        n++;
      end
    end
  end

  task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                      input logic urt, input logic iv, input logic [4:0] erw, input logic ew,
                      input logic [1:0] em, input logic [1:0] fa, input logic [1:0] fb,
                      input logic st, input int cnt);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    id_rs       = rs;
    id_rt       = rt;
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_valid    = iv;
    ex_rw       = erw;
    ex_regwrite = ew;
    ex_memtoreg = em;
    exp_q.push_back(mk(fa, fb, st, cnt));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b1;
    {id_rs, id_rt, id_use_rs, id_use_rt, id_valid} = '0;
    {ex_rw, ex_regwrite, ex_memtoreg} = '0;
    exp_q.push_back(mk(2'd0, 2'd0, 1'b0, 0));
    @(negedge clk);
    //      rs  rt urs urt iv  erw ew em   fa fb st cnt
    // forward from MEM
    step( 1,  2, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0);
    step( 3,  5, 1, 1, 1,  3, 1, 0,  0, 0, 0, 0);
    step( 0,  0, 0, 0, 1,  4, 1, 0,  1, 0, 0, 0);
    // MEM beats WB, then WB alone after a nop
    step( 1,  1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0);
    step( 1,  1, 1, 1, 1,  3, 1, 0,  0, 0, 0, 0);
    step( 3,  3, 1, 1, 1,  3, 1, 0,  0, 0, 0, 0);
    step( 0,  0, 0, 0, 1,  6, 1, 0,  1, 1, 0, 0);
    step( 1,  1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0);
    step( 0,  0, 0, 0, 1,  3, 1, 0,  0, 0, 0, 0);
    step( 3,  3, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0);
    step( 0,  0, 0, 0, 1,  6, 1, 0,  2, 2, 0, 0);
    // load-use
    step( 1,  0, 1, 0, 1,  0, 0, 0,  0, 0, 0, 0);
    step( 2,  1, 1, 1, 1,  2, 1, 1,  0, 0, 1, 0);
    step( 2,  1, 1, 1, 1,  0, 0, 0,  0, 0, 0, 1);
    step( 0,  0, 0, 0, 1,  7, 1, 0,  2, 0, 0, 1);
    // jal-use, then $0 never stalls nor forwards
    step(31,  0, 1, 0, 1, 31, 1, 2,  0, 0, 1, 1);
    step(31,  0, 1, 0, 1,  0, 0, 0,  0, 0, 0, 2);
    step( 0,  0, 0, 0, 1,  0, 0, 0,  2, 0, 0, 2);
    step( 0,  0, 1, 1, 1,  0, 1, 1,  0, 0, 0, 2);
    step( 0,  0, 1, 1, 1,  0, 1, 0,  0, 0, 0, 2);
    step( 0,  0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 2);
    // unused rt and flushed ID suppress the hazard
    step( 1,  2, 1, 0, 1,  2, 1, 1,  0, 0, 0, 2);
    step( 2,  2, 1, 1, 0,  2, 1, 1,  0, 0, 0, 2);
    step( 0,  0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 2);
    // both operands on one load: single stall; then forced hazards to saturate CNT_W = 2
    step( 4,  4, 1, 1, 1,  4, 1, 1,  0, 0, 1, 2);
    step( 4,  4, 1, 1, 1,  0, 0, 0,  0, 0, 0, 3);
    step( 0,  0, 0, 0, 1,  9, 1, 0,  2, 2, 0, 3);
    step( 5,  0, 1, 0, 1,  5, 1, 1,  0, 0, 1, 3);
    step( 5,  0, 1, 0, 1,  5, 1, 1,  0, 0, 1, 4);
    step( 5,  0, 1, 0, 1,  5, 1, 2,  0, 0, 1, 5);
    step( 0,  0, 0, 0, 1,  3, 1, 0,  0, 0, 0, 6);
    // load shadow state, then reset while the hazard is up
    step( 3,  3, 1, 1, 1,  3, 1, 0,  0, 0, 0, 6);
    step( 8,  0, 1, 0, 1,  8, 1, 1,  1, 1, 1, 6);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(mk(2'd0, 2'd0, 1'b0, 0));
    -> chk_ev;
    step( 3,  3, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0);
    step( 3,  3, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0);
    step( 3,  3, 1, 1, 1,  0, 0, 0,  0, 0, 0, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
